// File: rtl/taxi_pkg.sv
// Purpose: shared state encoding and default tariff constants for the taxi fare engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package taxi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int DEF_CLK_FREQ      = 50_000_000;
    localparam int DEF_DEB_CYC       = 1_000_000;
    localparam int DEF_PW            = 20;
    localparam int DEF_BASE_FARE     = 80;
    localparam int DEF_BASE_HM       = 30;
    localparam int DEF_RATE_KM_DAY   = 20;
    localparam int DEF_RATE_KM_NIGHT = 30;
    localparam int DEF_WAIT_RATE     = 10;
    localparam int DEF_PRICE_MAX     = 999_999;

    localparam int HM_PER_KM   = 10;
    localparam int SEC_PER_MIN = 60;

    // One decimal place on the 6-digit display.
    localparam logic [5:0] POINT_MASK = 6'b000_010;

endpackage

// File: rtl/key_debounce.sv
// Purpose: debounce one active-low key into a single-cycle press flag.
// Latency: press flag 2 sync cycles + DEB_CYC low samples after the key falls.
// Backpressure: none; one flag per press, re-armed only once the key returns high.
//
// Ports: sys_clk/sys_rst (sync active-high), key_n (raw active-low key),
//        press (registered one-cycle pulse).
module key_debounce #(
    parameter int DEB_CYC = 1_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0] CNT_FIRE = CW'(DEB_CYC - 1);
    // Counter parks one above the fire value so a held key cannot fire again.
    localparam logic [CW-1:0] CNT_TOP  = CW'(DEB_CYC);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    always_comb begin
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (sync2_q) begin
            cnt_d = '0;
        end else begin
            if (cnt_q != CNT_TOP) begin
                cnt_d = cnt_q + CW'(1);
            end
            press_d = (cnt_q == CNT_FIRE);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/taxi_fare_engine.sv
// Purpose: taxi meter core - key debounce, trip FSM, distance/wait accumulation, fare.
// Latency: price registered one cycle after the counter it depends on changes.
// Backpressure: none; keys are sampled every cycle, outputs are always valid.
//
// Ports: sys_clk/sys_rst (sync active-high); pulse_port/stat_port/end_port active-low keys;
//        night_mode latched at trip start; price (0.1 yuan), point, sign, seg_en,
//        stat_led (FSM code), dist_led (toggles per accepted 100 m pulse).
module taxi_fare_engine
    import taxi_pkg::*;
#(
    parameter int CLK_FREQ      = DEF_CLK_FREQ,
    parameter int DEB_CYC       = DEF_DEB_CYC,
    parameter int PW            = DEF_PW,
    parameter int BASE_FARE     = DEF_BASE_FARE,
    parameter int BASE_HM       = DEF_BASE_HM,
    parameter int RATE_KM_DAY   = DEF_RATE_KM_DAY,
    parameter int RATE_KM_NIGHT = DEF_RATE_KM_NIGHT,
    parameter int WAIT_RATE     = DEF_WAIT_RATE,
    parameter int PRICE_MAX     = DEF_PRICE_MAX
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          pulse_port,
    input  logic          stat_port,
    input  logic          end_port,
    input  logic          night_mode,
    output logic [PW-1:0] price,
    output logic [5:0]    point,
    output logic          sign,
    output logic          seg_en,
    output logic [1:0]    stat_led,
    output logic          dist_led
);

    localparam int TW  = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int KFW = $clog2(HM_PER_KM);
    localparam int MFW = $clog2(SEC_PER_MIN);
    localparam int FW  = 2 * PW + 8;

    localparam logic [PW-1:0]  CNT_MAX   = '1;
    localparam logic [PW-1:0]  BASE_HM_C = PW'(BASE_HM);
    localparam logic [TW-1:0]  TICK_LAST = TW'(CLK_FREQ - 1);
    localparam logic [KFW-1:0] KM_LAST   = KFW'(HM_PER_KM - 1);
    localparam logic [MFW-1:0] MIN_LAST  = MFW'(SEC_PER_MIN - 1);

    logic pulse_p, stat_p, end_p;

    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_pulse (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .key_n(pulse_port), .press(pulse_p));
    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_stat (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .key_n(stat_port), .press(stat_p));
    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_end (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .key_n(end_port), .press(end_p));

    state_t         state_q, state_d;
    logic           night_q, night_d;
    logic [PW-1:0]  dist_q, dist_d;
    logic [PW-1:0]  extra_km_q, extra_km_d;
    logic [KFW-1:0] km_frac_q, km_frac_d;    // hm beyond base, modulo one km
    logic [PW-1:0]  wait_s_q, wait_s_d;
    logic [PW-1:0]  wait_units_q, wait_units_d;
    logic [MFW-1:0] min_frac_q, min_frac_d;  // waiting seconds modulo one minute
    logic [TW-1:0]  tick_q, tick_d;
    logic           dist_led_q, dist_led_d;
    logic           seg_en_q;
    logic [PW-1:0]  price_q, price_d;
    logic           start;

    always_comb begin
        state_d      = state_q;
        night_d      = night_q;
        dist_d       = dist_q;
        extra_km_d   = extra_km_q;
        km_frac_d    = km_frac_q;
        wait_s_d     = wait_s_q;
        wait_units_d = wait_units_q;
        min_frac_d   = min_frac_q;
        tick_d       = tick_q;
        dist_led_d   = dist_led_q;
        start        = 1'b0;

        // end takes priority over stat wherever both are meaningful
        case (state_q)
            ST_IDLE:  if (stat_p) begin state_d = ST_DRIVE; start = 1'b1; end
            ST_DRIVE: if (end_p) state_d = ST_HOLD; else if (stat_p) state_d = ST_WAIT;
            ST_WAIT:  if (end_p) state_d = ST_HOLD; else if (stat_p) state_d = ST_DRIVE;
            ST_HOLD:  if (stat_p) begin state_d = ST_DRIVE; start = 1'b1; end
            default:  state_d = ST_IDLE;
        endcase

        // Pulses are judged on the state before any same-cycle transition.
        if (state_q == ST_DRIVE && pulse_p) begin
            dist_led_d = ~dist_led_q;
            if (dist_q != CNT_MAX) begin
                dist_d = dist_q + PW'(1);
                // New distance beyond base: every 10th hm starting at BASE_HM+1 opens a km.
                if (dist_q >= BASE_HM_C) begin
                    if (km_frac_q == '0 && extra_km_q != CNT_MAX) begin
                        extra_km_d = extra_km_q + PW'(1);
                    end
                    km_frac_d = (km_frac_q == KM_LAST) ? '0 : km_frac_q + KFW'(1);
                end
            end
        end

        if (state_q == ST_WAIT) begin
            if (tick_q == TICK_LAST) begin
                tick_d = '0;
                if (wait_s_q != CNT_MAX) begin
                    wait_s_d = wait_s_q + PW'(1);
                    // Second 60k+1 opens a new billed minute.
                    if (min_frac_q == '0 && wait_units_q != CNT_MAX) begin
                        wait_units_d = wait_units_q + PW'(1);
                    end
                    min_frac_d = (min_frac_q == MIN_LAST) ? '0 : min_frac_q + MFW'(1);
                end
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end
        // Partial seconds are discarded whenever WAIT is left.
        if (state_d != ST_WAIT) begin
            tick_d = '0;
        end

        if (start) begin
            night_d      = night_mode;
            dist_d       = '0;
            extra_km_d   = '0;
            km_frac_d    = '0;
            wait_s_d     = '0;
            wait_units_d = '0;
            min_frac_d   = '0;
            tick_d       = '0;
        end
    end

    logic [FW-1:0] rate_w;
    logic [FW-1:0] fare_w;

    // Counters are frozen in HOLD, so recomputing there keeps price frozen too.
    always_comb begin
        rate_w  = night_q ? FW'(RATE_KM_NIGHT) : FW'(RATE_KM_DAY);
        fare_w  = FW'(BASE_FARE) + FW'(extra_km_q) * rate_w
                + FW'(wait_units_q) * FW'(WAIT_RATE);
        price_d = '0;
        if (state_q != ST_IDLE) begin
            price_d = (fare_w > FW'(PRICE_MAX)) ? PW'(PRICE_MAX) : fare_w[PW-1:0];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            night_q      <= 1'b0;
            dist_q       <= '0;
            extra_km_q   <= '0;
            km_frac_q    <= '0;
            wait_s_q     <= '0;
            wait_units_q <= '0;
            min_frac_q   <= '0;
            tick_q       <= '0;
            dist_led_q   <= 1'b0;
            seg_en_q     <= 1'b0;
            price_q      <= '0;
        end else begin
            state_q      <= state_d;
            night_q      <= night_d;
            dist_q       <= dist_d;
            extra_km_q   <= extra_km_d;
            km_frac_q    <= km_frac_d;
            wait_s_q     <= wait_s_d;
            wait_units_q <= wait_units_d;
            min_frac_q   <= min_frac_d;
            tick_q       <= tick_d;
            dist_led_q   <= dist_led_d;
            seg_en_q     <= 1'b1;
            price_q      <= price_d;
        end
    end

    assign price    = price_q;
    assign point    = POINT_MASK;
    assign sign     = 1'b0;
    assign seg_en   = seg_en_q;
    assign stat_led = state_q;
    assign dist_led = dist_led_q;

endmodule

// File: doc/taxi_fare_engine.md
Name: taxi_fare_engine

Overview:
- Parametrised successor to the single-rate taxi meter data generator.
- Debounces three active-low keys: distance pulse, start/wait toggle, end-trip.
- Runs a 4-state trip FSM and accumulates distance and waiting time.
- Computes fare in 0.1-yuan units with selectable day/night km rate; output feeds the 6-digit segment display driver.

Parameters:
CLK_FREQ, 50_000_000, sys_clk cycles per second (wait tick)
DEB_CYC, 1_000_000, debounce hold cycles (20 ms)
PW, 20, price/counter width
BASE_FARE, 80, starting fare (8.0 yuan)
BASE_HM, 30, 100 m units included in base fare (3 km)
RATE_KM_DAY, 20, per started km beyond base (2.0 yuan)
RATE_KM_NIGHT, 30, night per-km rate (3.0 yuan)
WAIT_RATE, 10, per started waiting minute (1.0 yuan)
PRICE_MAX, 999_999, saturation ceiling (display limit)

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous active-high reset
pulse_port  in  1  active-low 100 m pulse key
stat_port  in  1  active-low start / drive-wait toggle key
end_port  in  1  active-low end-trip key
night_mode  in  1  1 = night rate, sampled at trip start
price  out  PW  fare, 0.1-yuan units
point  out  6  decimal-point mask
sign  out  1  minus sign, always 0
seg_en  out  1  display enable
stat_led  out  2  FSM state code
dist_led  out  1  toggles per accepted distance pulse

Behaviour:
- Interface: one clock, sys_clk; reset sys_rst, synchronous, active-high. All state changes occur on sys_clk rising edge.
- Reset values:
  - price=0, seg_en=0, dist_led=0, stat_led=IDLE, sign=0, point=6'b000_010.
  - All counters, flags and the latched night bit cleared.
- seg_en goes 1 on the first cycle after reset deasserts. point is constant 6'b000_010 (one decimal place).
- Debounce (per key):
  - Counter clears while key=1 and increments while key=0.
  - When the count reaches DEB_CYC-1, emit a one-cycle press flag.
  - Only one flag per press; re-arm only after the key returns to 1.
  - A low period shorter than DEB_CYC cycles produces no flag.
- FSM states: IDLE=0, DRIVE=1, WAIT=2, HOLD=3.
  - IDLE + stat -> DRIVE: clear distance, wait and fare counters; latch night_mode.
  - DRIVE + stat -> WAIT; WAIT + stat -> DRIVE.
  - HOLD + stat -> DRIVE: same clear and latch as from IDLE.
  - DRIVE/WAIT + end -> HOLD. end in IDLE or HOLD is ignored.
  - end and stat in the same cycle: end wins.
- Distance:
  - Pulse flags are counted only in DRIVE; ignored in IDLE, WAIT and HOLD.
  - On each accepted pulse: dist_hm+1 and dist_led toggles.
  - A pulse coincident with a state flag is judged on the pre-transition state.
- Waiting:
  - A tick counter runs only in WAIT, counting 0..CLK_FREQ-1; it clears on leaving WAIT.
  - Each wrap adds 1 to wait_s. wait_s persists across DRIVE/WAIT toggles within a trip.
- Fare:
  - extra_km = ceil(max(0, dist_hm-BASE_HM)/10), maintained incrementally (no divider). It increments when dist_hm becomes BASE_HM+1+10k.
  - wait_units = ceil(wait_s/60), incremented when wait_s becomes 60k+1.
  - price = min(PRICE_MAX, BASE_FARE + extra_km*rate + wait_units*WAIT_RATE), where rate comes from the latched night bit.
  - price is registered with 1-cycle latency after the counter update.
  - price=0 in IDLE. In HOLD, price and all counters are frozen.
  - night_mode changes mid-trip have no effect.
- Counters saturate at 2^PW-1; no wrap-around.

Decomposition:
- Shared package taxi_pkg: state encodings (IDLE/DRIVE/WAIT/HOLD), fare default constants, HM_PER_KM=10, SEC_PER_MIN=60.
- Sub-module key_debounce (parameter DEB_CYC; ports sys_clk, sys_rst, key_n, press), instantiated three times.

Test Plan:
All scenarios run with DEB_CYC=4, CLK_FREQ=10.
- Reset: sys_rst high 3 cycles, then low → price=0, stat_led=0, seg_en=0 then 1 next cycle, point=6'b000_010.
- Day distance: stat press, then pulses → price 80 after 30 pulses; 100 after 31; 100 after 40; 120 after 41. dist_led toggled 41 times.
- Waiting: start, stat press into WAIT with no distance → price 80 at 0 s; 90 after 10 cycles (1 s); 90 at 60 s; 100 at 61 s. Toggle to DRIVE and back → wait_s continues, no double charge.
- Night rate: night_mode=1 at start, then night_mode=0 → 31 pulses give price 110.
- Hold/restart: end in DRIVE → stat_led=3, price frozen, further pulses ignored. stat press → DRIVE, price 80. end+stat in the same cycle from DRIVE → HOLD.
- Debounce/saturation: pulse_port low 3 cycles → no count; low 200 cycles → exactly one count. PRICE_MAX=100 with 60 pulses → price pinned at 100.
